// File: rtl/cs_dec_arb.sv
// Round-robin request arbiter feeding a fixed-latency erasure decoder, with a credit-limited
// result FIFO. Define CS_DEC_ARB_STATS_EN to enable the saturating issue/failure counters.
module cs_dec_arb #(
    parameter int NCH   = 4,
    parameter int M     = 2,
    parameter int K     = 3,
    parameter int WIDTH = 4,
    parameter int LAT   = 2,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NCH-1:0]           req_valid,
    output logic [NCH-1:0]           req_ready,
    input  logic [NCH*K-1:0]         req_erasure,
    input  logic [NCH*K*WIDTH-1:0]   req_coded,
    output logic                     dec_valid_in,
    output logic [K-1:0]             dec_erasure,
    output logic [K*WIDTH-1:0]       dec_coded_in,
    input  logic                     dec_valid_out,
    input  logic                     dec_ok,
    input  logic [M*WIDTH-1:0]       dec_data_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(NCH)-1:0]   out_ch,
    output logic                     out_ok,
    output logic [M*WIDTH-1:0]       out_data,
    output logic                     err_sync,
    output logic [15:0]              stat_issue_cnt,
    output logic [15:0]              stat_fail_cnt
);
    localparam int CW = $clog2(NCH);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NW = $clog2(DEPTH + 1);
    localparam int DW = M * WIDTH;
    localparam int EW = CW + 1 + DW;

    logic [CW-1:0] rr_ptr, gnt_ch, dec_ch;
    logic [CW:0]   rr_sum;
    logic          gnt_found, issue;
    logic [NW-1:0] inflight, fifo_cnt;
    logic [NW:0]   credit;
    logic [LAT-1:0] tag_v;
    logic [CW-1:0] tag_ch [LAT];
    logic          ret_v, push, pop;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] head;

    // First requester at or after rr_ptr, wrapping NCH-1 -> 0.
    always_comb begin
        gnt_ch    = '0;
        gnt_found = 1'b0;
        rr_sum    = '0;
        for (int i = 0; i < NCH; i++) begin
            rr_sum = {1'b0, rr_ptr} + (CW+1)'(i);
            if (rr_sum >= (CW+1)'(NCH)) rr_sum = rr_sum - (CW+1)'(NCH);
            if (!gnt_found && req_valid[rr_sum[CW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_ch    = rr_sum[CW-1:0];
            end
        end
    end

    assign credit = {1'b0, inflight} + {1'b0, fifo_cnt};
    assign issue  = rst_n && gnt_found && (credit < (NW+1)'(DEPTH));

    always_comb begin
        req_ready = '0;
        if (issue) req_ready[gnt_ch] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr       <= '0;
            dec_valid_in <= 1'b0;
            dec_erasure  <= '0;
            dec_coded_in <= '0;
            dec_ch       <= '0;
        end else begin
            dec_valid_in <= issue;
            if (issue) begin
                rr_ptr       <= (gnt_ch == CW'(NCH - 1)) ? '0 : gnt_ch + CW'(1);
                dec_erasure  <= req_erasure[int'(gnt_ch)*K +: K];
                dec_coded_in <= req_coded[int'(gnt_ch)*K*WIDTH +: K*WIDTH];
                dec_ch       <= gnt_ch;
            end
        end
    end

    // Tag pipeline starts at dec_valid_in so its last stage lines up with dec_valid_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v <= '0;
            for (int i = 0; i < LAT; i++) tag_ch[i] <= '0;
        end else begin
            tag_v[0]  <= dec_valid_in;
            tag_ch[0] <= dec_ch;
            for (int i = 1; i < LAT; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_ch[i] <= tag_ch[i-1];
            end
        end
    end

    assign ret_v = tag_v[LAT-1];
    assign push  = dec_valid_out && ret_v;
    assign pop   = out_valid && out_ready;

    // A retiring tag releases its credit even if the decoder failed to answer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
            err_sync <= 1'b0;
        end else begin
            if (issue && !ret_v)      inflight <= inflight + NW'(1);
            else if (!issue && ret_v) inflight <= inflight - NW'(1);
            if (dec_valid_out != ret_v) err_sync <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            if (pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            if (push && !pop)      fifo_cnt <= fifo_cnt + NW'(1);
            else if (!push && pop) fifo_cnt <= fifo_cnt - NW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {tag_ch[LAT-1], dec_ok, dec_data_out};
    end

    assign out_valid                  = (fifo_cnt != '0);
    assign head                       = out_valid ? mem[rd_ptr] : '0;
    assign {out_ch, out_ok, out_data} = head;

`ifdef CS_DEC_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_issue_cnt <= '0;
            stat_fail_cnt  <= '0;
        end else begin
            if (issue && stat_issue_cnt != 16'hFFFF) stat_issue_cnt <= stat_issue_cnt + 16'd1;
            if (push && !dec_ok && stat_fail_cnt != 16'hFFFF)
                stat_fail_cnt <= stat_fail_cnt + 16'd1;
        end
    end
`else
    assign stat_issue_cnt = '0;
    assign stat_fail_cnt  = '0;
`endif

endmodule

// File: tb/tb_cs_dec_arb.sv
// Directed bench for cs_dec_arb: arbitration table, latency, fairness, backpressure,
// decode failures, return mismatch and mid-operation reset.
module tb_cs_dec_arb;
    localparam int NCH   = 4;
    localparam int M     = 2;
    localparam int K     = 3;
    localparam int WIDTH = 4;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;
    localparam int DW    = M * WIDTH;
    localparam logic [DW-1:0] XMASK = 8'h5A;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [NCH-1:0]         req_valid = '0;
    logic [NCH-1:0]         req_ready;
    logic [NCH*K-1:0]       req_erasure = '0;
    logic [NCH*K*WIDTH-1:0] req_coded = '0;
    logic                   dec_valid_in;
    logic [K-1:0]           dec_erasure;
    logic [K*WIDTH-1:0]     dec_coded_in;
    logic                   dec_valid_out;
    logic                   dec_ok;
    logic [DW-1:0]          dec_data_out;
    logic                   out_valid;
    logic                   out_ready = 1'b1;
    logic [1:0]             out_ch;
    logic                   out_ok;
    logic [DW-1:0]          out_data;
    logic                   err_sync;
    logic [15:0]            stat_issue_cnt, stat_fail_cnt;

    always #5 clk = ~clk;

    cs_dec_arb #(.NCH(NCH), .M(M), .K(K), .WIDTH(WIDTH), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_erasure(req_erasure), .req_coded(req_coded),
        .dec_valid_in(dec_valid_in), .dec_erasure(dec_erasure), .dec_coded_in(dec_coded_in),
        .dec_valid_out(dec_valid_out), .dec_ok(dec_ok), .dec_data_out(dec_data_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
        .out_ok(out_ok), .out_data(out_data),
        .err_sync(err_sync), .stat_issue_cnt(stat_issue_cnt), .stat_fail_cnt(stat_fail_cnt)
    );

    // Decoder model: LAT-cycle pipe; succeeds with at most K-M erasures.
    logic [LAT-1:0] p_v;
    logic           p_ok [LAT];
    logic [DW-1:0]  p_d [LAT];
    logic           inject = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_v <= '0;
            for (int i = 0; i < LAT; i++) begin
                p_ok[i] <= 1'b0;
                p_d[i]  <= '0;
            end
        end else begin
            p_v[0]  <= dec_valid_in;
            p_ok[0] <= ($countones(dec_erasure) <= K - M);
            p_d[0]  <= ($countones(dec_erasure) <= K - M) ? (dec_coded_in[DW-1:0] ^ XMASK) : '0;
            for (int i = 1; i < LAT; i++) begin
                p_v[i]  <= p_v[i-1];
                p_ok[i] <= p_ok[i-1];
                p_d[i]  <= p_d[i-1];
            end
        end
    end

    assign dec_valid_out = p_v[LAT-1] | inject;
    assign dec_ok        = p_ok[LAT-1];
    assign dec_data_out  = p_d[LAT-1];

    typedef struct { int ch; logic ok; logic [DW-1:0] data; } sb_t;
    sb_t sb[$];
    sb_t mon_e;

    typedef struct { logic [NCH-1:0] valid; logic [NCH-1:0] ready; } vec_t;
    vec_t tbl [12];

    int checks = 0, errors = 0;
    int seed = 0, exp_rr = 0, exp_issue = 0, exp_fail = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] sym(input int ch, input int j, input int s);
        return WIDTH'(ch * K + j + s);
    endfunction

    task automatic set_payload(input int s);
        seed = s;
        for (int c = 0; c < NCH; c++)
            for (int j = 0; j < K; j++)
                req_coded[(c*K + j)*WIDTH +: WIDTH] = sym(c, j, s);
    endtask

    task automatic sb_push(input int ch);
        sb_t e;
        logic [K-1:0] er;
        logic [DW-1:0] xm;
        xm   = XMASK;
        er   = req_erasure[ch*K +: K];
        e.ch = ch;
        e.ok = ($countones(er) <= K - M);
        e.data = '0;
        for (int j = 0; j < M; j++)
            e.data[j*WIDTH +: WIDTH] = sym(ch, j, seed) ^ xm[j*WIDTH +: WIDTH];
        if (!e.ok) e.data = '0;
        sb.push_back(e);
        exp_issue++;
        if (!e.ok) exp_fail++;
    endtask

    task automatic wait_drain(input string name);
        int i;
        i = 0;
        while (sb.size() != 0 && i < 40) begin
            tick();
            i++;
        end
        check(name, sb.size(), 0);
    endtask

    task automatic check_stats(input string name);
`ifdef CS_DEC_ARB_STATS_EN
        check({name, "_issue"}, stat_issue_cnt, exp_issue);
        check({name, "_fail"}, stat_fail_cnt, exp_fail);
`else
        check({name, "_issue"}, stat_issue_cnt, 0);
        check({name, "_fail"}, stat_fail_cnt, 0);
`endif
    endtask

    // Scoreboard: every accepted output must match the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got ch %0d, required no output", out_ch);
            end else begin
                mon_e = sb.pop_front();
                check("out_ch", out_ch, mon_e.ch);
                check("out_ok", out_ok, mon_e.ok);
                check("out_data", out_data, mon_e.data);
            end
        end
    end

    initial begin
        logic [K*WIDTH-1:0] exp_coded;
        int n, got, cnt [NCH];

        tbl[0]  = '{4'b1111, 4'b1000};
        tbl[1]  = '{4'b1111, 4'b0001};
        tbl[2]  = '{4'b0101, 4'b0100};
        tbl[3]  = '{4'b0011, 4'b0001};
        tbl[4]  = '{4'b0011, 4'b0010};
        tbl[5]  = '{4'b0000, 4'b0000};
        tbl[6]  = '{4'b0011, 4'b0001};
        tbl[7]  = '{4'b1000, 4'b1000};
        tbl[8]  = '{4'b1001, 4'b0001};
        tbl[9]  = '{4'b0110, 4'b0010};
        tbl[10] = '{4'b1110, 4'b0100};
        tbl[11] = '{4'b0111, 4'b0001};

        // Reset state, with a request pending to prove req_ready is held low.
        set_payload(0);
        req_valid = 4'b0001;
        #2;
        check("rst_req_ready", req_ready, 0);
        check("rst_dec", {dec_valid_in, dec_erasure, dec_coded_in}, 0);
        check("rst_out", {out_valid, out_ch, out_ok, out_data}, 0);
        check("rst_err_sync", err_sync, 0);
        check_stats("rst_stat");
        req_valid = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Single request on ch2: dec_valid_in at t+1, out_valid at t+4.
        set_payload(5);
        req_valid = 4'b0100;
        #1;
        check("single_ready", req_ready, 4'b0100);
        sb_push(2);
        exp_rr = 3;
        tick();
        req_valid = '0;
        for (int j = 0; j < K; j++) exp_coded[j*WIDTH +: WIDTH] = sym(2, j, 5);
        check("single_dec_valid", dec_valid_in, 1);
        check("single_dec_coded", dec_coded_in, exp_coded);
        check("single_dec_erasure", dec_erasure, 0);
        check("single_out_t1", out_valid, 0);
        tick();
        check("single_dec_pulse", dec_valid_in, 0);
        check("single_out_t2", out_valid, 0);
        tick();
        check("single_out_t3", out_valid, 0);
        tick();
        check("single_out_t4", out_valid, 1);
        check("single_out_ch", out_ch, 2);
        check("single_out_data", out_data, {sym(2, 1, 5), sym(2, 0, 5)} ^ XMASK);
        wait_drain("single_drain");

        // Arbitration table, each vector isolated by idle cycles.
        for (int i = 0; i < 12; i++) begin
            set_payload(16 + i);
            req_valid = tbl[i].valid;
            #1;
            check($sformatf("tbl%0d_ready", i), req_ready, tbl[i].ready);
            for (int c = 0; c < NCH; c++)
                if (tbl[i].ready[c]) begin
                    sb_push(c);
                    exp_rr = (c + 1) % NCH;
                end
            tick();
            req_valid = '0;
            for (int w = 0; w < 4; w++) tick();
        end
        wait_drain("tbl_drain");

        // Fairness: all channels valid, 12 issues rotate from the current pointer.
        set_payload(40);
        for (int c = 0; c < NCH; c++) cnt[c] = 0;
        req_valid = '1;
        n = 0;
        for (int cyc = 0; cyc < 100 && n < 12; cyc++) begin
            #1;
            if (req_ready != '0) begin
                check($sformatf("fair%0d_grant", n), req_ready, 1 << exp_rr);
                for (int c = 0; c < NCH; c++) if (req_ready[c]) cnt[c]++;
                sb_push(exp_rr);
                exp_rr = (exp_rr + 1) % NCH;
                n++;
            end
            tick();
        end
        req_valid = '0;
        check("fair_issues", n, 12);
        for (int c = 0; c < NCH; c++) check($sformatf("fair_cnt_ch%0d", c), cnt[c], 3);
        wait_drain("fair_drain");

        // Backpressure: credit limits issues to DEPTH, then drain in order and resume.
        set_payload(60);
        out_ready = 1'b0;
        req_valid = '1;
        n = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            #1;
            if (req_ready != '0) begin
                check($sformatf("bp%0d_grant", n), req_ready, 1 << exp_rr);
                sb_push(exp_rr);
                exp_rr = (exp_rr + 1) % NCH;
                n++;
            end
            tick();
        end
        check("bp_issues", n, DEPTH);
        check("bp_ready_stalled", req_ready, 0);
        check("bp_out_valid", out_valid, 1);
        check("bp_head_ch", out_ch, sb[0].ch);
        tick();
        check("bp_head_hold", out_ch, sb[0].ch);
        out_ready = 1'b1;
        got = 0;
        for (int cyc = 0; cyc < 30 && got == 0; cyc++) begin
            #1;
            if (req_ready != '0) begin
                check("bp_resume_grant", req_ready, 1 << exp_rr);
                sb_push(exp_rr);
                exp_rr = (exp_rr + 1) % NCH;
                got = 1;
            end
            tick();
        end
        req_valid = '0;
        check("bp_resumed", got, 1);
        wait_drain("bp_drain");

        // Decode failures: 1 erasure decodes, 2 or 3 do not.
        for (int p = 0; p < 3; p++) begin
            set_payload(80 + p);
            req_erasure[1*K +: K] = (p == 0) ? 3'b001 : (p == 1) ? 3'b011 : 3'b111;
            req_valid = 4'b0010;
            #1;
            check($sformatf("fail%0d_ready", p), req_ready, 4'b0010);
            sb_push(1);
            exp_rr = 2;
            tick();
            req_valid = '0;
            for (int w = 0; w < 5; w++) tick();
        end
        req_erasure = '0;
        wait_drain("fail_drain");
        check("fail_exp_model", exp_fail, 2);
        check_stats("fail_stat");

        // Return with no matching tag: sticky err_sync, nothing pushed.
        check("mm_err_before", err_sync, 0);
        inject = 1'b1;
        tick();
        inject = 1'b0;
        check("mm_err_set", err_sync, 1);
        for (int w = 0; w < 5; w++) tick();
        check("mm_err_held", err_sync, 1);
        check("mm_no_push", out_valid, 0);

        // Reset with two results buffered and two still in the decoder.
        set_payload(100);
        out_ready = 1'b0;
        req_valid = '1;
        for (int w = 0; w < 4; w++) tick();
        req_valid = '0;
        tick();
        check("rr_buffered", out_valid, 1);
        req_valid = '1;
        rst_n = 1'b0;
        #1;
        check("rr_req_ready", req_ready, 0);
        check("rr_dec", {dec_valid_in, dec_erasure, dec_coded_in}, 0);
        check("rr_out", {out_valid, out_ch, out_ok, out_data}, 0);
        check("rr_err_sync", err_sync, 0);
        sb.delete();
        exp_issue = 0;
        exp_fail  = 0;
        exp_rr    = 0;
        check_stats("rr_stat");
        tick();
        req_valid = '0;
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int w = 0; w < 8; w++) begin
            tick();
            check($sformatf("rr_quiet%0d", w), out_valid, 0);
        end
        set_payload(120);
        req_valid = 4'b1000;
        #1;
        check("rr_new_ready", req_ready, 4'b1000);
        sb_push(3);
        tick();
        req_valid = '0;
        wait_drain("rr_new_drain");
        check_stats("final_stat");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
